// File: rtl/ppi_mode1_strobe_ctrl_if.sv
// CPU-side register bus of the PPI Mode 1 handshake stage.
// The master drives select, strobes and write data; the slave returns read data.
interface ppi_mode1_strobe_ctrl_if;
  logic [1:0] a;
  logic       write;
  logic       read;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_en;

  modport master (output a, write, read, din, input dout, dout_en);
  modport slave  (input a, write, read, din, output dout, dout_en);
endinterface

// File: rtl/ppi_mode1_strobe_ctrl.sv
// PPI Mode 1 strobed-I/O handshake: Port A strobed input, Port B strobed output,
// control word decode (mode select, INTE bit set/reset) and Port C status readback.
module ppi_mode1_strobe_ctrl #(
  parameter int unsigned SyncStages = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  ppi_mode1_strobe_ctrl_if.slave cpu_io,
  input  logic [7:0]             pa_in_i,
  input  logic                   stb_a_n_i,
  output logic [7:0]             pb_out_o,
  input  logic                   ack_b_n_i,
  output logic                   ibf_a_o,
  output logic                   intr_a_o,
  output logic                   obf_b_n_o,
  output logic                   intr_b_o,
  output logic                   mode1_a_o,
  output logic                   mode1_b_o
);

  logic [SyncStages-1:0] stb_sync_q, ack_sync_q;
  logic                  stb_prev_q, ack_prev_q;
  logic                  stb_s, ack_s;
  logic                  stb_fall, stb_rise, ack_fall, ack_rise;
  logic                  write_q, read_q;
  logic                  wr_start, wr_end, rd_start, rd_end;
  logic                  sel_a, sel_b, sel_ctl;

  logic       mode1_a_q, mode1_a_d, mode1_b_q, mode1_b_d;
  logic       inte_a_q, inte_a_d, inte_b_q, inte_b_d;
  logic       ibf_q, ibf_d, intr_a_q, intr_a_d;
  logic       obf_n_q, obf_n_d, intr_b_q, intr_b_d;
  logic [7:0] latch_q, latch_d, pb_q, pb_d;

  // Synchroniser output plus one registered sample gives the edge detector.
  assign stb_s    = stb_sync_q[SyncStages-1];
  assign ack_s    = ack_sync_q[SyncStages-1];
  assign stb_fall = stb_prev_q & ~stb_s;
  assign stb_rise = ~stb_prev_q & stb_s;
  assign ack_fall = ack_prev_q & ~ack_s;
  assign ack_rise = ~ack_prev_q & ack_s;

  assign wr_start = cpu_io.write & ~write_q;
  assign wr_end   = ~cpu_io.write & write_q;
  assign rd_start = cpu_io.read & ~read_q;
  assign rd_end   = ~cpu_io.read & read_q;
  assign sel_a    = (cpu_io.a == 2'd0);
  assign sel_b    = (cpu_io.a == 2'd1);
  assign sel_ctl  = (cpu_io.a == 2'd3);

  always_comb begin
    mode1_a_d = mode1_a_q;
    mode1_b_d = mode1_b_q;
    inte_a_d  = inte_a_q;
    inte_b_d  = inte_b_q;
    ibf_d     = ibf_q;
    intr_a_d  = intr_a_q;
    obf_n_d   = obf_n_q;
    intr_b_d  = intr_b_q;
    latch_d   = latch_q;
    pb_d      = pb_q;

    // Later assignments take priority: sets are placed after clears.
    if (mode1_a_q) begin
      if (rd_start && sel_a) intr_a_d = 1'b0;
      if (rd_end && sel_a) ibf_d = 1'b0;
      if (stb_fall) begin
        latch_d = pa_in_i;
        ibf_d   = 1'b1;
      end
      if (stb_rise && ibf_q && inte_a_q) intr_a_d = 1'b1;
    end

    if (mode1_b_q) begin
      if (wr_start && sel_b) begin
        pb_d     = cpu_io.din;
        intr_b_d = 1'b0;
      end
      if (ack_fall) obf_n_d = 1'b1;
      if (wr_end && sel_b) obf_n_d = 1'b0;
      if (ack_rise && obf_n_q && inte_b_q) intr_b_d = 1'b1;
    end

    if (wr_start && sel_ctl) begin
      if (cpu_io.din[7]) begin
        mode1_a_d = (cpu_io.din[6:5] == 2'b01) && cpu_io.din[4];
        mode1_b_d = cpu_io.din[2] && !cpu_io.din[1];
        inte_a_d  = 1'b0;
        inte_b_d  = 1'b0;
        ibf_d     = 1'b0;
        intr_a_d  = 1'b0;
        intr_b_d  = 1'b0;
        obf_n_d   = 1'b1;
        pb_d      = 8'h00;
      end else if (cpu_io.din[3:1] == 3'd4) begin
        inte_a_d = cpu_io.din[0];
      end else if (cpu_io.din[3:1] == 3'd2) begin
        inte_b_d = cpu_io.din[0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stb_sync_q <= '1;
      ack_sync_q <= '1;
      stb_prev_q <= 1'b1;
      ack_prev_q <= 1'b1;
      write_q    <= 1'b0;
      read_q     <= 1'b0;
      mode1_a_q  <= 1'b0;
      mode1_b_q  <= 1'b0;
      inte_a_q   <= 1'b0;
      inte_b_q   <= 1'b0;
      ibf_q      <= 1'b0;
      intr_a_q   <= 1'b0;
      obf_n_q    <= 1'b1;
      intr_b_q   <= 1'b0;
      latch_q    <= 8'h00;
      pb_q       <= 8'h00;
    end else begin
      stb_sync_q <= {stb_sync_q[SyncStages-2:0], stb_a_n_i};
      ack_sync_q <= {ack_sync_q[SyncStages-2:0], ack_b_n_i};
      stb_prev_q <= stb_s;
      ack_prev_q <= ack_s;
      write_q    <= cpu_io.write;
      read_q     <= cpu_io.read;
      mode1_a_q  <= mode1_a_d;
      mode1_b_q  <= mode1_b_d;
      inte_a_q   <= inte_a_d;
      inte_b_q   <= inte_b_d;
      ibf_q      <= ibf_d;
      intr_a_q   <= intr_a_d;
      obf_n_q    <= obf_n_d;
      intr_b_q   <= intr_b_d;
      latch_q    <= latch_d;
      pb_q       <= pb_d;
    end
  end

  assign cpu_io.dout_en = cpu_io.read && !sel_ctl;

  always_comb begin
    cpu_io.dout = 8'h00;
    if (cpu_io.dout_en) begin
      unique case (cpu_io.a)
        2'd0:    cpu_io.dout = latch_q;
        2'd1:    cpu_io.dout = pb_q;
        2'd2:    cpu_io.dout = {2'b00, ibf_q, inte_a_q, intr_a_q, inte_b_q, obf_n_q, intr_b_q};
        default: cpu_io.dout = 8'h00;
      endcase
    end
  end

  assign pb_out_o  = pb_q;
  assign ibf_a_o   = ibf_q;
  assign intr_a_o  = intr_a_q;
  assign obf_b_n_o = obf_n_q;
  assign intr_b_o  = intr_b_q;
  assign mode1_a_o = mode1_a_q;
  assign mode1_b_o = mode1_b_q;

endmodule

// File: tb/tb_ppi_mode1_strobe_ctrl.sv
// Bench for ppi_mode1_strobe_ctrl: directed vector table, two hand-built
// coincident-event sequences, then random traffic against a reference model.
module tb_ppi_mode1_strobe_ctrl;
  localparam int unsigned SS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pa;
  logic       stb_n, ack_n;
  logic [7:0] pb_out;
  logic       ibf_a, intr_a, obf_b_n, intr_b, mode1_a, mode1_b;

  ppi_mode1_strobe_ctrl_if bus ();

  ppi_mode1_strobe_ctrl #(.SyncStages(SS)) dut (
    .clk_i     (clk),
    .reset_i   (rst),
    .cpu_io    (bus),
    .pa_in_i   (pa),
    .stb_a_n_i (stb_n),
    .pb_out_o  (pb_out),
    .ack_b_n_i (ack_n),
    .ibf_a_o   (ibf_a),
    .intr_a_o  (intr_a),
    .obf_b_n_o (obf_b_n),
    .intr_b_o  (intr_b),
    .mode1_a_o (mode1_a),
    .mode1_b_o (mode1_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit model_chk = 1'b0;

  // Reference model: abstract state plus pin history; a pin edge takes effect SS+1 clocks later.
  bit       m_ma, m_mb, m_inte_a, m_inte_b, m_ibf, m_intr_a, m_obf, m_intr_b;
  bit [7:0] m_latch, m_pb;
  bit       m_wr_prev, m_rd_prev;
  bit       stb_h [SS+1];
  bit       ack_h [SS+1];

  typedef struct {
    logic       rst;
    logic [1:0] a;
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [7:0] pa;
    logic       stb_n;
    logic       ack_n;
    logic [5:0] flags;  // {mode1_a, mode1_b, ibf_a, intr_a, obf_b_n, intr_b}
    logic [7:0] dout;
    logic       den;
    logic [7:0] pb;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic [1:0] a, logic wr, logic rd, logic [7:0] din,
                              logic [7:0] p, logic s, logic k, logic [5:0] f, logic [7:0] d,
                              logic de, logic [7:0] b);
    vec_t v;
    v = '{r, a, wr, rd, din, p, s, k, f, d, de, b};
    vecs.push_back(v);
  endfunction

  function automatic logic [22:0] obs();
    return {mode1_a, mode1_b, ibf_a, intr_a, obf_b_n, intr_b, bus.dout, bus.dout_en, pb_out};
  endfunction

  task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    bit ws, we, rs, re, sf, sr, af, ar;
    if (rst) begin
      {m_ma, m_mb, m_inte_a, m_inte_b, m_ibf, m_intr_a, m_intr_b} = '0;
      m_obf = 1'b1;
      m_latch = 8'h00;
      m_pb = 8'h00;
      m_wr_prev = 1'b0;
      m_rd_prev = 1'b0;
      for (int i = 0; i <= SS; i++) begin
        stb_h[i] = 1'b1;
        ack_h[i] = 1'b1;
      end
      return;
    end
    ws = bus.write && !m_wr_prev;
    we = !bus.write && m_wr_prev;
    rs = bus.read && !m_rd_prev;
    re = !bus.read && m_rd_prev;
    sf = stb_h[SS] && !stb_h[SS-1];
    sr = !stb_h[SS] && stb_h[SS-1];
    af = ack_h[SS] && !ack_h[SS-1];
    ar = !ack_h[SS] && ack_h[SS-1];
    for (int i = SS; i > 0; i--) begin
      stb_h[i] = stb_h[i-1];
      ack_h[i] = ack_h[i-1];
    end
    stb_h[0] = stb_n;
    ack_h[0] = ack_n;
    m_wr_prev = bus.write;
    m_rd_prev = bus.read;

    if (ws && bus.a == 2'd3 && bus.din[7]) begin
      m_ma = (bus.din[6:5] == 2'b01) && bus.din[4];
      m_mb = bus.din[2] && !bus.din[1];
      {m_inte_a, m_inte_b, m_ibf, m_intr_a, m_intr_b} = '0;
      m_obf = 1'b1;
      m_pb = 8'h00;
      if (sf && m_ma_old_guard()) m_latch = pa;
      return;
    end
    if (m_ma) begin
      if (sf) m_latch = pa;
      m_ibf = sf || (m_ibf && !(re && bus.a == 2'd0));
      m_intr_a = (sr && m_ibf_old(sf, re)) ? 1'b1 : m_intr_a && !(rs && bus.a == 2'd0);
    end
    if (m_mb) begin
      if (ws && bus.a == 2'd1) m_pb = bus.din;
      m_intr_b = (ar && m_obf && m_inte_b) || (m_intr_b && !(ws && bus.a == 2'd1));
      if (we && bus.a == 2'd1) m_obf = 1'b0;
      else if (af) m_obf = 1'b1;
    end
    if (ws && bus.a == 2'd3) begin
      if (bus.din[3:1] == 3'd4) m_inte_a = bus.din[0];
      if (bus.din[3:1] == 3'd2) m_inte_b = bus.din[0];
    end
  endtask

  // Port A capture still happens on a mode-word cycle if Group A was enabled beforehand.
  bit m_ma_prev;
  function automatic bit m_ma_old_guard();
    return m_ma_prev;
  endfunction

  // Interrupt on STB rise needs IBF and INTE_A as they stood before this edge.
  bit m_ibf_prev;
  function automatic bit m_ibf_old(bit sf, bit re);
    return m_ibf_prev && m_inte_a && !sf && (re || !re);
  endfunction

  function automatic logic [7:0] model_dout();
    if (!bus.read) return 8'h00;
    case (bus.a)
      2'd0:    return m_latch;
      2'd1:    return m_pb;
      2'd2:    return {2'b00, m_ibf, m_inte_a, m_intr_a, m_inte_b, m_obf, m_intr_b};
      default: return 8'h00;
    endcase
  endfunction

  task automatic tick();
    m_ma_prev = m_ma;
    m_ibf_prev = m_ibf;
    model_edge();
    @(posedge clk);
    #1;
    if (model_chk)
      check("random", obs(), {m_ma, m_mb, m_ibf, m_intr_a, m_obf, m_intr_b, model_dout(),
                              bus.read && (bus.a != 2'd3), m_pb});
  endtask

  task automatic cyc(input logic r, input logic [1:0] a, input logic wr, input logic rd,
                     input logic [7:0] din, input logic s, input logic k);
    rst = r; bus.a = a; bus.write = wr; bus.read = rd; bus.din = din; stb_n = s; ack_n = k;
    tick();
  endtask

  initial begin
    int op_left;
    rst = 1'b1; bus.a = 2'd0; bus.write = 1'b0; bus.read = 1'b0; bus.din = 8'h00;
    pa = 8'h00; stb_n = 1'b1; ack_n = 1'b1;

    // rst a wr rd din pa stb ack | flags dout den pb
    add(1,0,0,0,8'h00,8'h00,1,1, 6'b000010,8'h00,0,8'h00);
    add(0,0,0,0,8'h00,8'h00,1,1, 6'b000010,8'h00,0,8'h00);
    add(0,3,1,0,8'hB4,8'h00,1,1, 6'b110010,8'h00,0,8'h00);
    add(0,3,0,0,8'hB4,8'h00,1,1, 6'b110010,8'h00,0,8'h00);
    add(0,2,0,1,8'h00,8'h00,1,1, 6'b110010,8'h02,1,8'h00);
    add(0,2,0,0,8'h00,8'h00,1,1, 6'b110010,8'h00,0,8'h00);
    add(0,3,1,0,8'h09,8'h00,1,1, 6'b110010,8'h00,0,8'h00);
    add(0,3,0,0,8'h09,8'h5A,1,1, 6'b110010,8'h00,0,8'h00);
    add(0,3,0,0,8'h00,8'h5A,0,1, 6'b110010,8'h00,0,8'h00);
    add(0,3,0,0,8'h00,8'h5A,0,1, 6'b110010,8'h00,0,8'h00);
    add(0,3,0,0,8'h00,8'h5A,0,1, 6'b111010,8'h00,0,8'h00);
    add(0,3,0,0,8'h00,8'h5A,0,1, 6'b111010,8'h00,0,8'h00);
    add(0,3,0,0,8'h00,8'h5A,1,1, 6'b111010,8'h00,0,8'h00);
    add(0,3,0,0,8'h00,8'h5A,1,1, 6'b111010,8'h00,0,8'h00);
    add(0,3,0,0,8'h00,8'h5A,1,1, 6'b111110,8'h00,0,8'h00);
    add(0,0,0,1,8'h00,8'h00,1,1, 6'b111010,8'h5A,1,8'h00);
    add(0,0,0,1,8'h00,8'h00,1,1, 6'b111010,8'h5A,1,8'h00);
    add(0,0,0,0,8'h00,8'h00,1,1, 6'b110010,8'h00,0,8'h00);
    add(0,3,1,0,8'h05,8'h00,1,1, 6'b110010,8'h00,0,8'h00);
    add(0,3,0,0,8'h05,8'h00,1,1, 6'b110010,8'h00,0,8'h00);
    add(0,1,1,0,8'hC3,8'h00,1,1, 6'b110010,8'h00,0,8'hC3);
    add(0,1,0,0,8'hC3,8'h00,1,1, 6'b110000,8'h00,0,8'hC3);
    add(0,1,0,0,8'h00,8'h00,1,0, 6'b110000,8'h00,0,8'hC3);
    add(0,1,0,0,8'h00,8'h00,1,0, 6'b110000,8'h00,0,8'hC3);
    add(0,1,0,0,8'h00,8'h00,1,0, 6'b110010,8'h00,0,8'hC3);
    add(0,1,0,0,8'h00,8'h00,1,1, 6'b110010,8'h00,0,8'hC3);
    add(0,1,0,0,8'h00,8'h00,1,1, 6'b110010,8'h00,0,8'hC3);
    add(0,1,0,0,8'h00,8'h00,1,1, 6'b110011,8'h00,0,8'hC3);
    add(0,2,0,1,8'h00,8'h00,1,1, 6'b110011,8'h17,1,8'hC3);
    add(0,2,0,0,8'h00,8'h00,1,1, 6'b110011,8'h00,0,8'hC3);
    add(0,1,1,0,8'h3C,8'h00,1,1, 6'b110010,8'h00,0,8'h3C);
    add(0,1,0,0,8'h3C,8'h00,1,1, 6'b110000,8'h00,0,8'h3C);
    add(0,3,1,0,8'h08,8'h00,1,1, 6'b110000,8'h00,0,8'h3C);
    add(0,3,0,0,8'h08,8'h00,1,1, 6'b110000,8'h00,0,8'h3C);
    add(0,3,0,0,8'h00,8'h77,0,1, 6'b110000,8'h00,0,8'h3C);
    add(0,3,0,0,8'h00,8'h77,0,1, 6'b110000,8'h00,0,8'h3C);
    add(0,3,0,0,8'h00,8'h77,0,1, 6'b111000,8'h00,0,8'h3C);
    add(0,3,0,0,8'h00,8'h77,1,1, 6'b111000,8'h00,0,8'h3C);
    add(0,3,0,0,8'h00,8'h77,1,1, 6'b111000,8'h00,0,8'h3C);
    add(0,3,0,0,8'h00,8'h77,1,1, 6'b111000,8'h00,0,8'h3C);
    add(0,2,0,1,8'h00,8'h77,1,1, 6'b111000,8'h24,1,8'h3C);
    add(0,2,0,0,8'h00,8'h77,1,1, 6'b111000,8'h00,0,8'h3C);
    add(0,0,0,1,8'h00,8'h11,0,1, 6'b111000,8'h77,1,8'h3C);
    add(0,0,0,1,8'h00,8'h11,0,1, 6'b111000,8'h77,1,8'h3C);
    add(0,0,0,0,8'h00,8'h11,0,1, 6'b111000,8'h00,0,8'h3C);
    add(0,0,0,1,8'h00,8'h11,0,1, 6'b111000,8'h11,1,8'h3C);
    add(0,0,0,0,8'h00,8'h11,0,1, 6'b110000,8'h00,0,8'h3C);
    add(0,3,1,0,8'h09,8'h11,0,1, 6'b110000,8'h00,0,8'h3C);
    add(0,3,0,0,8'h09,8'h11,0,1, 6'b110000,8'h00,0,8'h3C);
    add(0,3,0,0,8'h00,8'h11,1,1, 6'b110000,8'h00,0,8'h3C);
    add(0,3,0,0,8'h00,8'h99,0,1, 6'b110000,8'h00,0,8'h3C);
    add(0,3,0,0,8'h00,8'h99,0,1, 6'b110000,8'h00,0,8'h3C);
    add(0,3,0,0,8'h00,8'h99,0,1, 6'b111000,8'h00,0,8'h3C);
    add(0,3,0,0,8'h00,8'h99,1,1, 6'b111000,8'h00,0,8'h3C);
    add(0,3,0,0,8'h00,8'h99,1,1, 6'b111000,8'h00,0,8'h3C);
    add(0,3,0,0,8'h00,8'h99,1,1, 6'b111100,8'h00,0,8'h3C);
    add(1,3,0,0,8'h00,8'h99,1,1, 6'b000010,8'h00,0,8'h00);
    add(0,0,0,1,8'h00,8'h99,1,1, 6'b000010,8'h00,1,8'h00);
    add(0,0,0,0,8'h00,8'h99,1,1, 6'b000010,8'h00,0,8'h00);
    add(0,3,1,0,8'h80,8'h99,1,1, 6'b000010,8'h00,0,8'h00);
    add(0,3,0,0,8'h80,8'h99,1,1, 6'b000010,8'h00,0,8'h00);
    add(0,1,1,0,8'hAA,8'h99,0,0, 6'b000010,8'h00,0,8'h00);
    add(0,1,0,0,8'hAA,8'h99,0,0, 6'b000010,8'h00,0,8'h00);
    add(0,1,0,0,8'h00,8'h99,0,0, 6'b000010,8'h00,0,8'h00);
    add(0,1,0,0,8'h00,8'h99,0,0, 6'b000010,8'h00,0,8'h00);
    add(0,1,0,0,8'h00,8'h99,1,1, 6'b000010,8'h00,0,8'h00);
    add(0,1,0,0,8'h00,8'h99,1,1, 6'b000010,8'h00,0,8'h00);
    add(0,0,0,1,8'h00,8'h99,1,1, 6'b000010,8'h00,1,8'h00);
    add(0,0,0,0,8'h00,8'h99,1,1, 6'b000010,8'h00,0,8'h00);
    add(0,3,0,1,8'h00,8'h99,1,1, 6'b000010,8'h00,0,8'h00);
    add(0,3,0,0,8'h00,8'h99,1,1, 6'b000010,8'h00,0,8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; bus.a = vecs[i].a; bus.write = vecs[i].wr; bus.read = vecs[i].rd;
      bus.din = vecs[i].din; pa = vecs[i].pa; stb_n = vecs[i].stb_n; ack_n = vecs[i].ack_n;
      tick();
      check($sformatf("row%0d", i), obs(),
            {vecs[i].flags, vecs[i].dout, vecs[i].den, vecs[i].pb});
    end

    // Setup: both groups in Mode 1 with INTE_A and INTE_B set.
    cyc(1, 0, 0, 0, 8'h00, 1, 1);
    cyc(0, 3, 1, 0, 8'hB4, 1, 1);
    cyc(0, 3, 0, 0, 8'hB4, 1, 1);
    cyc(0, 3, 1, 0, 8'h09, 1, 1);
    cyc(0, 3, 0, 0, 8'h09, 1, 1);
    cyc(0, 3, 1, 0, 8'h05, 1, 1);
    cyc(0, 3, 0, 0, 8'h05, 1, 1);

    // STB rise lands on the same edge as a Port A read start.
    pa = 8'h42;
    cyc(0, 0, 0, 0, 8'h00, 0, 1);
    cyc(0, 0, 0, 0, 8'h00, 1, 1);
    cyc(0, 0, 0, 0, 8'h00, 1, 1);
    cyc(0, 0, 0, 1, 8'h00, 1, 1);
    check("rise_vs_rdstart_intr_a", 23'(intr_a), 23'd1);
    check("rise_vs_rdstart_ibf", 23'(ibf_a), 23'd1);
    check("rise_vs_rdstart_dout", 23'(bus.dout), 23'h42);
    cyc(0, 0, 0, 0, 8'h00, 1, 1);
    check("rdend_ibf_clr", 23'({ibf_a, intr_a}), 23'b01);

    // Write end coincides with ACK fall; later write start coincides with ACK rise.
    cyc(0, 1, 1, 0, 8'h5C, 1, 0);
    cyc(0, 1, 1, 0, 8'h5C, 1, 0);
    cyc(0, 1, 0, 0, 8'h5C, 1, 0);
    check("wrend_vs_ackfall_obf", 23'({obf_b_n, pb_out}), {15'd0, 8'h5C});
    cyc(0, 1, 0, 0, 8'h00, 1, 1);
    cyc(0, 1, 0, 0, 8'h00, 1, 0);
    cyc(0, 1, 0, 0, 8'h00, 1, 0);
    cyc(0, 1, 0, 0, 8'h00, 1, 0);
    check("ackfall_obf_set", 23'({obf_b_n, intr_b}), 23'b10);
    cyc(0, 1, 0, 0, 8'h00, 1, 1);
    cyc(0, 1, 0, 0, 8'h00, 1, 1);
    cyc(0, 1, 1, 0, 8'h66, 1, 1);
    check("rise_vs_wrstart_intr_b", 23'({intr_b, pb_out}), {15'd1, 8'h66});
    cyc(0, 1, 0, 0, 8'h66, 1, 1);
    check("wrend_obf_clr", 23'({obf_b_n, intr_b}), 23'b01);

    // Random traffic against the reference model.
    cyc(1, 0, 0, 0, 8'h00, 1, 1);
    model_chk = 1'b1;
    op_left = 0;
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (op_left != 0) begin
        op_left--;
        if (op_left == 0) begin
          bus.write = 1'b0;
          bus.read = 1'b0;
        end
      end else if (!bus.write && !bus.read && $urandom_range(0, 3) == 0) begin
        bus.a = 2'($urandom_range(0, 3));
        bus.din = 8'($urandom);
        if (bus.a == 2'd3) begin
          if ($urandom_range(0, 4) == 0)
            bus.din = ($urandom_range(0, 3) != 0) ? 8'hB4 : (8'($urandom) | 8'h80);
          else
            bus.din = {4'h0, ($urandom_range(0, 1) != 0) ? 3'd4 : 3'd2, 1'($urandom)};
        end
        if ($urandom_range(0, 1) != 0) bus.write = 1'b1;
        else bus.read = 1'b1;
        op_left = $urandom_range(1, 3);
      end
      pa = 8'($urandom);
      if ($urandom_range(0, 5) == 0) stb_n = ~stb_n;
      if ($urandom_range(0, 5) == 0) ack_n = ~ack_n;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppi_mode1_strobe_ctrl.md
Name: ppi_mode1_strobe_ctrl

Overview:
- Mode 1 (strobed I/O) handshake stage of the PPI, sitting between the CPU bus decoder and the peripheral pins.
- Port A is a strobed input, latched on STB_A_N and signalled by IBF_A and INTR_A.
- Port B is a strobed output, signalled by OBF_B_N, acknowledged by ACK_B_N, and raises INTR_B.
- It also decodes the control word for mode select and Port C bit set/reset (INTE bits), and returns the Port C status byte.

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages synchronising STB_A_N and ACK_B_N (minimum 2).

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- A  in  2  register select: 0 = Port A, 1 = Port B, 2 = Port C status, 3 = control.
- WRITE  in  1  active-high CPU write strobe, level, at least 1 CLK.
- READ  in  1  active-high CPU read strobe, level, at least 1 CLK.
- DIN  in  8  CPU write data.
- DOUT  out  8  CPU read data.
- DOUT_EN  out  1  bus drive enable.
- PA_IN  in  8  Port A pins.
- STB_A_N  in  1  peripheral strobe, asynchronous, active low.
- PB_OUT  out  8  Port B output latch.
- ACK_B_N  in  1  peripheral acknowledge, asynchronous, active low.
- IBF_A  out  1  Port A input buffer full.
- INTR_A  out  1  Port A interrupt.
- OBF_B_N  out  1  Port B output buffer full, active low.
- INTR_B  out  1  Port B interrupt.
- MODE1_A  out  1  Group A is configured as Mode 1 input.
- MODE1_B  out  1  Group B is configured as Mode 1 output.

Behaviour:
- Clock and reset: single clock CLK. RESET is synchronous and active-high.
- Reset values: PB_OUT=0x00, IBF_A=0, INTR_A=0, OBF_B_N=1, INTR_B=0, MODE1_A=0, MODE1_B=0, INTE_A=0, INTE_B=0, input latch=0x00, DOUT=0x00, DOUT_EN=0.
- Reset mid-handshake aborts it; all state returns to the reset values above.
- CPU strobes are synchronous; the previous values of WRITE and READ are registered.
  - Write start: WRITE=1 and previous WRITE=0. Write end: WRITE=0 and previous WRITE=1.
  - Read start and read end are defined the same way from READ.
  - A is sampled at start and must be held stable until end.
- Peripheral inputs STB_A_N and ACK_B_N pass through the SYNC_STAGES synchroniser, then a registered edge detector. Fall-to-detect latency is SYNC_STAGES+1 CLK.
- Control write (A=3, at write start):
  - DIN[7]=1 (mode word): MODE1_A = DIN[6:5]==01 and DIN[4]==1. MODE1_B = DIN[2]==1 and DIN[1]==0.
  - A mode word also clears IBF_A, INTR_A, INTR_B, INTE_A, INTE_B, sets OBF_B_N=1, and clears PB_OUT.
  - DIN[7]=0 (bit set/reset): bit index DIN[3:1], value DIN[0]. Index 4 writes INTE_A; index 2 writes INTE_B; other indices are ignored.
- Port A, active only when MODE1_A=1:
  - Synchronised STB fall: capture PA_IN into the input latch and set IBF_A. The peripheral holds PA_IN stable for at least SYNC_STAGES+2 CLK after STB_A_N falls.
  - Synchronised STB rise with IBF_A=1 and INTE_A=1: set INTR_A.
  - Read start at A=0: clear INTR_A. Read end at A=0: clear IBF_A.
  - Simultaneous events: set beats clear. A STB fall in the same cycle as a read end leaves IBF_A=1 with new data. A STB rise in the same cycle as a read start leaves INTR_A=1.
  - A STB fall while IBF_A=1 overwrites the latch; this is an overrun and is not flagged.
- Port B, active only when MODE1_B=1:
  - Write start at A=1: PB_OUT<=DIN and clear INTR_B.
  - Write end at A=1: OBF_B_N<=0.
  - Synchronised ACK fall: OBF_B_N<=1.
  - Synchronised ACK rise with OBF_B_N=1 and INTE_B=1: set INTR_B.
  - Simultaneous events: a write end in the same cycle as an ACK fall gives OBF_B_N=0 (write wins). A write start in the same cycle as an ACK rise gives INTR_B=1 (set wins).
- Reads (combinational):
  - DOUT_EN = READ and A≠3.
  - A=0: input latch. A=1: PB_OUT.
  - A=2: {2'b00, IBF_A, INTE_A, INTR_A, INTE_B, OBF_B_N, INTR_B} (bits 7..0).
  - When DOUT_EN=0, DOUT=0x00.
- Disabled group: when its MODE1_x=0, that group's flags hold their values and its strobes and edges are ignored. Writes to A=0 are always ignored.

Test Plan:
- Reset then mode word 0xB4 -> MODE1_A=1, MODE1_B=1, OBF_B_N=1, status read at A=2 returns 0x02.
- BSR 0x09 (set INTE_A); PA_IN=0x5A; pulse STB_A_N low for 4 CLK -> IBF_A=1 exactly 3 CLK after the fall, INTR_A=1 after the synchronised rise; read A=0 returns 0x5A, INTR_A=0 at read start, IBF_A=0 at read end.
- BSR 0x05 (set INTE_B); write 0xC3 to A=1 -> PB_OUT=0xC3, OBF_B_N=0 after WRITE falls; pulse ACK_B_N low -> OBF_B_N=1, then INTR_B=1 after the rise; next write -> INTR_B=0 at write start.
- With INTE_A=0, complete a STB cycle -> IBF_A=1, INTR_A stays 0; status read returns bit 5 set and bit 3 clear.
- Align a synchronised STB fall with a read end at A=0, with PA_IN=0x11 -> IBF_A remains 1 and the latch holds 0x11.
- With OBF_B_N=0 and INTR_A=1, assert RESET for 1 CLK -> all outputs return to their reset values; a mode word of 0x80 -> MODE1_A=0, MODE1_B=0, and later strobes have no effect.
